// File: rtl/tcdm_arb_pkg.sv
// Shared definitions for the TCDM bank arbiter and the bank adapter behind it.
// - amo_op_t : atomic opcode carried on every request (same encoding as the adapter)
// - idx_width: bit width needed to hold a requester index
package tcdm_arb_pkg;

  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOLR   = 4'hA,
    AMOSC   = 4'hB
  } amo_op_t;

  // A single requester still needs one bit so index types never collapse to zero width.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO without fall-through: data_o shows the current head,
// a push becomes visible one cycle later.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i write side;
//        pop_i/data_o read side; full_o/empty_o status.
// Pushes while full and pops while empty are ignored. DEPTH must be a power of 2
// so the pointers wrap for free.
module fifo_v3 #(
  parameter  int unsigned DATA_WIDTH = 2,
  parameter  int unsigned DEPTH      = 4,
  localparam int unsigned AddrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AddrW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [AddrW:0]        count_reg;
  logic                  do_push, do_pop;

  assign full_o  = (count_reg == (AddrW+1)'(DEPTH));
  assign empty_o = (count_reg == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem[rd_ptr_reg];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AddrW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AddrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AddrW+1)'(1);
        2'b01:   count_reg <= count_reg - (AddrW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset: contents are only read behind a non-zero count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_reg] <= data_i;
  end

endmodule

// File: rtl/rr_sticky_arbiter.sv
// Round-robin arbiter with a sticky grant.
// Ports: clk_i/rst_ni clock and async active-low reset; eligible per-requester
//        request mask; ready downstream accept; valid grant presented;
//        winner index of the granted requester.
// The search starts at rr_ptr and wraps. Once a grant is presented and not
// accepted, the winner is frozen until the handshake so the downstream side
// sees a stable request even if the pointer or the mask changes.
module rr_sticky_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter  int unsigned NumIn = 4,
  localparam int unsigned IdxW  = idx_width(NumIn)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumIn-1:0] eligible,
  input  logic             ready,
  output logic             valid,
  output logic [IdxW-1:0]  winner
);

  typedef logic [IdxW-1:0] idx_t;

  idx_t        rr_ptr_reg, rr_ptr_next;
  idx_t        lock_idx_reg, lock_idx_next;
  logic        lock_reg, lock_next;
  idx_t        search_idx;
  logic        found;
  int unsigned cand;

  // First eligible index at or after rr_ptr, cyclic.
  always_comb begin
    search_idx = rr_ptr_reg;
    found      = 1'b0;
    cand       = 0;
    for (int unsigned k = 0; k < NumIn; k++) begin
      cand = 32'(rr_ptr_reg) + k;
      if (cand >= NumIn) cand = cand - NumIn;
      if (!found && eligible[cand[IdxW-1:0]]) begin
        search_idx = cand[IdxW-1:0];
        found      = 1'b1;
      end
    end
  end

  assign winner = lock_reg ? lock_idx_reg : search_idx;
  // Equals |eligible when unlocked; when locked it follows the held requester only.
  assign valid  = eligible[winner];

  always_comb begin
    rr_ptr_next   = rr_ptr_reg;
    lock_next     = valid && !ready;
    lock_idx_next = lock_idx_reg;
    if (valid && !ready) lock_idx_next = winner;
    if (valid && ready) begin
      rr_ptr_next = (winner == idx_t'(NumIn - 1)) ? '0 : winner + idx_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_reg   <= '0;
      lock_reg     <= 1'b0;
      lock_idx_reg <= '0;
    end else begin
      rr_ptr_reg   <= rr_ptr_next;
      lock_reg     <= lock_next;
      lock_idx_reg <= lock_idx_next;
    end
  end

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Shares one TCDM bank adapter between NumIn requesters.
// Ports: clk_i/rst_ni clock and async active-low reset;
//        req_*   per-requester valid/ready request channel (addr, amo, write, wdata, be, meta);
//        rsp_*   per-requester response valid/ready, shared rdata/meta;
//        bank_*  muxed request towards the adapter;
//        bank_rsp_* in-order response from the adapter.
// An ID FIFO remembers which requester owns each in-flight request; the adapter
// answers in order, so the FIFO head names the owner of the current response.
// Both paths are purely combinational: no cycles are added.
module tcdm_bank_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter  int unsigned NumIn          = 4,
  parameter  int unsigned AddrWidth      = 32,
  parameter  int unsigned DataWidth      = 32,
  parameter  int unsigned MaxOutstanding = 4,
  parameter  type         metadata_t     = logic,
  localparam int unsigned BeWidth        = DataWidth / 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic      [NumIn-1:0]           req_valid_i,
  output logic      [NumIn-1:0]           req_ready_o,
  input  logic      [NumIn-1:0][AddrWidth-1:0] req_addr_i,
  input  amo_op_t   [NumIn-1:0]           req_amo_i,
  input  logic      [NumIn-1:0]           req_write_i,
  input  logic      [NumIn-1:0][DataWidth-1:0] req_wdata_i,
  input  logic      [NumIn-1:0][BeWidth-1:0]   req_be_i,
  input  metadata_t [NumIn-1:0]           req_meta_i,
  output logic      [NumIn-1:0]           rsp_valid_o,
  input  logic      [NumIn-1:0]           rsp_ready_i,
  output logic      [DataWidth-1:0]       rsp_rdata_o,
  output metadata_t                       rsp_meta_o,
  output logic                            bank_valid_o,
  input  logic                            bank_ready_i,
  output logic      [AddrWidth-1:0]       bank_addr_o,
  output amo_op_t                         bank_amo_o,
  output logic                            bank_write_o,
  output logic      [DataWidth-1:0]       bank_wdata_o,
  output logic      [BeWidth-1:0]         bank_be_o,
  output metadata_t                       bank_meta_o,
  input  logic                            bank_rsp_valid_i,
  output logic                            bank_rsp_ready_o,
  input  logic      [DataWidth-1:0]       bank_rsp_rdata_i,
  input  metadata_t                       bank_rsp_meta_i
);

  localparam int unsigned IdxW = idx_width(NumIn);
  typedef logic [IdxW-1:0] idx_t;

  idx_t             winner;
  idx_t             head;
  logic             fifo_full, fifo_empty;
  logic [NumIn-1:0] eligible;
  logic             req_hs, rsp_hs;

  // A full FIFO blocks every requester, even if a response drains it this
  // cycle; this also guarantees the sticky lock is never taken while full.
  assign eligible = fifo_full ? '0 : req_valid_i;

  rr_sticky_arbiter #(
    .NumIn(NumIn)
  ) i_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .eligible(eligible),
    .ready   (bank_ready_i),
    .valid   (bank_valid_o),
    .winner  (winner)
  );

  assign req_hs = bank_valid_o && bank_ready_i;

  // Fields are zeroed while idle so the adapter never sees stale requester data.
  always_comb begin
    bank_addr_o  = '0;
    bank_amo_o   = AMONone;
    bank_write_o = 1'b0;
    bank_wdata_o = '0;
    bank_be_o    = '0;
    bank_meta_o  = '0;
    if (bank_valid_o) begin
      bank_addr_o  = req_addr_i[winner];
      bank_amo_o   = req_amo_i[winner];
      bank_write_o = req_write_i[winner];
      bank_wdata_o = req_wdata_i[winner];
      bank_be_o    = req_be_i[winner];
      bank_meta_o  = req_meta_i[winner];
    end
  end

  fifo_v3 #(
    .DATA_WIDTH(IdxW),
    .DEPTH     (MaxOutstanding)
  ) i_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .data_i (winner),
    .push_i (req_hs),
    .data_o (head),
    .pop_i  (rsp_hs)
  );

  assign bank_rsp_ready_o = rsp_ready_i[head] && !fifo_empty;
  assign rsp_hs           = bank_rsp_valid_i && bank_rsp_ready_o;
  assign rsp_rdata_o      = bank_rsp_rdata_i;
  assign rsp_meta_o       = bank_rsp_meta_i;

  for (genvar gi = 0; gi < NumIn; gi++) begin : g_port
    assign req_ready_o[gi] = req_hs && (winner == idx_t'(gi));
    assign rsp_valid_o[gi] = bank_rsp_valid_i && !fifo_empty && (head == idx_t'(gi));
  end

  // A response with nothing in flight means the adapter and this block disagree.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(bank_rsp_valid_i && fifo_empty))
    else $fatal(1, "tcdm_bank_arbiter: response received with empty ID FIFO");

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
module tb_tcdm_bank_arbiter;
  import tcdm_arb_pkg::*;

  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         req_valid, req_ready;
  logic [N-1:0][31:0]   req_addr;
  amo_op_t [N-1:0]      req_amo;
  logic [N-1:0]         req_write;
  logic [N-1:0][31:0]   req_wdata;
  logic [N-1:0][3:0]    req_be;
  logic [N-1:0]         req_meta;
  logic [N-1:0]         rsp_valid, rsp_ready;
  logic [31:0]          rsp_rdata;
  logic                 rsp_meta;
  logic                 bank_valid, bank_ready;
  logic [31:0]          bank_addr;
  amo_op_t              bank_amo;
  logic                 bank_write;
  logic [31:0]          bank_wdata;
  logic [3:0]           bank_be;
  logic                 bank_meta;
  logic                 bank_rsp_valid, bank_rsp_ready;
  logic [31:0]          bank_rsp_rdata;
  logic                 bank_rsp_meta;

  int checks = 0;
  int failures = 0;

  typedef struct { int idx; amo_op_t amo; } grant_t;
  typedef struct { int idx; logic [31:0] data; } rsp_t;
  grant_t grant_q[$];
  rsp_t   rsp_q[$];
  grant_t mon_g;
  rsp_t   mon_r;
  logic [3:0] mon_oh;

  tcdm_bank_arbiter #(
    .NumIn(N), .AddrWidth(32), .DataWidth(32), .MaxOutstanding(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_amo_i(req_amo), .req_write_i(req_write), .req_wdata_i(req_wdata),
    .req_be_i(req_be), .req_meta_i(req_meta),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_meta_o(rsp_meta),
    .bank_valid_o(bank_valid), .bank_ready_i(bank_ready), .bank_addr_o(bank_addr),
    .bank_amo_o(bank_amo), .bank_write_o(bank_write), .bank_wdata_o(bank_wdata),
    .bank_be_o(bank_be), .bank_meta_o(bank_meta),
    .bank_rsp_valid_i(bank_rsp_valid), .bank_rsp_ready_o(bank_rsp_ready),
    .bank_rsp_rdata_i(bank_rsp_rdata), .bank_rsp_meta_i(bank_rsp_meta)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] addr_of(int i);
    return 32'hA000_0000 + 32'(i) * 32'h100;
  endfunction

  function automatic logic [31:0] wdata_of(int i);
    return 32'hD0D0_0000 + 32'(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_grant(input int idx, input amo_op_t amo);
    grant_t g;
    g.idx = idx;
    g.amo = amo;
    grant_q.push_back(g);
  endtask

  task automatic exp_rsp(input int idx, input logic [31:0] d);
    rsp_t r;
    r.idx  = idx;
    r.data = d;
    rsp_q.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Adapter side: present one response and hold it until accepted (bounded).
  task automatic send_rsp(input int idx, input logic [31:0] d);
    int n;
    n = 0;
    bank_rsp_valid = 1'b1;
    bank_rsp_rdata = d;
    exp_rsp(idx, d);
    forever begin
      @(negedge clk);
      if (bank_rsp_ready) break;
      n++;
      if (n > 20) begin
        checks++;
        failures++;
        $display("FAIL rsp_timeout: owner %0d never accepted, got ready=0 expected 1", idx);
        break;
      end
    end
    step();
    bank_rsp_valid = 1'b0;
    bank_rsp_rdata = '0;
  endtask

  // Monitor: pops the scoreboards on every request and response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bank_valid && bank_ready) begin
        if (grant_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL grant_unexpected: got grant addr %0h ready %b expected none", bank_addr, req_ready);
        end else begin
          mon_g  = grant_q.pop_front();
          mon_oh = 4'b0001 << mon_g.idx;
          $display("grant  req=%0d addr=%0h amo=%0d", mon_g.idx, bank_addr, bank_amo);
          chk("grant_addr",  bank_addr,  addr_of(mon_g.idx));
          chk("grant_ready", req_ready,  mon_oh);
          chk("grant_amo",   bank_amo,   mon_g.amo);
          chk("grant_wdata", bank_wdata, wdata_of(mon_g.idx));
        end
      end
      if (bank_rsp_valid && bank_rsp_ready) begin
        if (rsp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected: got rsp_valid %b expected none", rsp_valid);
        end else begin
          mon_r  = rsp_q.pop_front();
          mon_oh = 4'b0001 << mon_r.idx;
          $display("rsp    req=%0d data=%0h", mon_r.idx, rsp_rdata);
          chk("rsp_valid", rsp_valid, mon_oh);
          chk("rsp_rdata", rsp_rdata, mon_r.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[4];
    seq = '{1, 3, 1, 2};
    req_valid = '0; bank_ready = 1'b0; rsp_ready = 4'b1111;
    bank_rsp_valid = 1'b0; bank_rsp_rdata = '0; bank_rsp_meta = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_addr[i]  = addr_of(i);
      req_amo[i]   = AMONone;
      req_write[i] = i[0];
      req_wdata[i] = wdata_of(i);
      req_be[i]    = 4'hF;
      req_meta[i]  = i[0];
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset_bank_valid", bank_valid, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_bank_rsp_ready", bank_rsp_ready, 0);
    chk("reset_bank_addr", bank_addr, 0);
    step();

    // All four requesting: grants rotate 0,1,2,3,0,1,2,3 while responses drain
    bank_ready = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      if (c < 8) exp_grant(c % 4, AMONone);
      if (c >= 1) begin
        bank_rsp_valid = 1'b1;
        bank_rsp_rdata = 32'h5000_0000 + 32'(c);
        exp_rsp((c - 1) % 4, 32'h5000_0000 + 32'(c));
      end
      step();
    end
    bank_rsp_valid = 1'b0;
    req_valid = '0;

    // Move rr_ptr to 2 so a late req2 would win without the lock
    req_valid = 4'b0010; exp_grant(1, AMONone); step();
    req_valid = '0;
    send_rsp(1, 32'h6000_0001);

    // Sticky grant: req0 stalled, req2 arrives while stalled
    bank_ready = 1'b0; req_valid = 4'b0001;
    @(negedge clk);
    chk("stall_valid", bank_valid, 1);
    chk("stall_addr", bank_addr, addr_of(0));
    chk("stall_ready", req_ready, 0);
    step();
    req_valid = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("sticky_addr", bank_addr, addr_of(0));
      chk("sticky_ready", req_ready, 0);
      step();
    end
    bank_ready = 1'b1; exp_grant(0, AMONone); step();
    req_valid = 4'b0100; exp_grant(2, AMONone); step();
    req_valid = '0;
    send_rsp(0, 32'h6000_0002);
    send_rsp(2, 32'h6000_0003);

    // Fill the ID FIFO with 1,3,1,2; a 5th request must be blocked
    for (int k = 0; k < 4; k++) begin
      req_valid = 4'b0001 << seq[k];
      exp_grant(seq[k], AMONone);
      step();
    end
    req_valid = 4'b0001;
    @(negedge clk);
    chk("full_valid", bank_valid, 0);
    chk("full_ready", req_ready, 0);
    step();
    bank_rsp_valid = 1'b1; bank_rsp_rdata = 32'h7000_0000; exp_rsp(1, 32'h7000_0000);
    @(negedge clk);
    chk("full_pop_valid", bank_valid, 0);
    chk("full_pop_ready", req_ready, 0);
    step();
    // Slot freed: req0 is granted; head (req3) holds off its response
    exp_grant(0, AMONone);
    bank_rsp_rdata = 32'h7000_0001; rsp_ready = 4'b0111;
    @(negedge clk);
    chk("hold_bank_rsp_ready", bank_rsp_ready, 0);
    chk("hold_rsp_valid", rsp_valid, 4'b1000);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("hold_bank_rsp_ready", bank_rsp_ready, 0);
    chk("hold_rsp_valid", rsp_valid, 4'b1000);
    step();
    rsp_ready = 4'b1111; exp_rsp(3, 32'h7000_0001); step();
    bank_rsp_valid = 1'b0;
    send_rsp(1, 32'h7000_0002);
    send_rsp(2, 32'h7000_0003);
    send_rsp(0, 32'h7000_0004);

    // AMOAdd from req1, adapter stalls one cycle after accept, req2 waits
    req_valid = 4'b0110; req_amo[1] = AMOAdd; exp_grant(1, AMOAdd); step();
    req_amo[1] = AMONone; req_valid = 4'b0100; bank_ready = 1'b0;
    @(negedge clk);
    chk("amo_stall_valid", bank_valid, 1);
    chk("amo_stall_ready", req_ready, 0);
    step();
    bank_ready = 1'b1; exp_grant(2, AMONone); step();
    req_valid = '0;
    send_rsp(1, 32'h8000_0001);
    send_rsp(2, 32'h8000_0002);

    // Reset with three requests in flight
    req_valid = 4'b0111; exp_grant(0, AMONone); step();
    req_valid = 4'b0110; exp_grant(1, AMONone); step();
    req_valid = 4'b0100; exp_grant(2, AMONone); step();
    req_valid = '0; rst_n = 1'b0;
    @(negedge clk);
    chk("rst_bank_valid", bank_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_bank_rsp_ready", bank_rsp_ready, 0);
    chk("rst_bank_addr", bank_addr, 0);
    step();
    step();
    rst_n = 1'b1;
    req_valid = 4'b1000; exp_grant(3, AMONone);
    @(negedge clk);
    chk("post_rst_empty", bank_rsp_ready, 0);
    step();
    req_valid = '0;
    send_rsp(3, 32'h9000_0003);

    @(negedge clk);
    chk("grant_q_drained", 64'(grant_q.size()), 0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
